// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op arbiter: op codes, FSM state encoding and op latency.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   OP_*        3-bit op codes as seen by the decoder
//   state_e     arbiter FSM states
//   is_arith()  true for the add/sub ops that need the longer execute window
//   op_lat()    execute cycle count for a given op
package alu_pkg;

  // Op codes presented to the decoder. OP_A (000) decodes to a live select,
  // which is why op_en must qualify every decoder output.
  localparam logic [2:0] OP_A   = 3'b000;
  localparam logic [2:0] OP_B   = 3'b001;
  localparam logic [2:0] OP_C   = 3'b010;
  localparam logic [2:0] OP_D   = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AWE = 3'b110;
  localparam logic [2:0] OP_F   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Add and sub are the only ops with op[2]=1 and op[1]=0.
  function automatic logic is_arith(input logic [2:0] op);
    return op[2] & ~op[1];
  endfunction

  // Number of cycles the op stays on the decoder (op_en high).
  function automatic logic [2:0] op_lat(input logic [2:0] op,
                                        input logic [2:0] arith_cyc,
                                        input logic [2:0] other_cyc);
    return is_arith(op) ? arith_cyc : other_cyc;
  endfunction

endpackage

// File: rtl/alu_op_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid_i at or after ptr_i, wrapping past NREQ-1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   valid_i  NREQ  request vector
//   ptr_i    IW    highest-priority index this cycle (must be < NREQ)
//   gnt_o    NREQ  one-hot grant, all zero when nothing is valid
//   idx_o    IW    binary index of the granted requester (0 when none)
//   any_o    1     at least one requester is valid
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // Scan offsets from farthest to nearest so the nearest valid requester
  // (smallest distance from ptr_i, wrapping) is the last one written.
  always_comb begin
    int         pos;
    logic [IW-1:0] pos_idx;
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      pos_idx = IW'(pos);
      if (valid_i[pos_idx]) begin
        gnt_o          = '0;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one ALU op decoder/adder between NREQ requesters.
// Latency: accept -> first op_en cycle = 1; op_en held lat(op) cycles; done 1 cycle after; lat+2 per op.
// Backpressure: req_ready pulses only in IDLE; requesters hold req_valid/req_op until their req_ready.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]    requester i has an op pending
//   req_op     [3*NREQ]  op of requester i at [3i+2:3i]
//   req_lock   [NREQ]    requester i keeps priority for its next op (sampled when its op completes)
//   req_ready  [NREQ]    one-hot accept pulse (combinational, IDLE only)
//   done       [NREQ]    one-hot completion pulse
//   op_out     [3]       op presented to the decoder (000 whenever op_en is low)
//   op_en      1         op_out is valid
//   busy       1         arbiter is not idle
module alu_op_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ARITH_CYC = 2,
  parameter int OTHER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   done,
  output logic [2:0]        op_out,
  output logic              op_en,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] ARITH_LAT = 3'(ARITH_CYC);
  localparam logic [2:0] OTHER_LAT = 3'(OTHER_CYC);

  // FSM and datapath state
  state_e          state_q;
  logic [2:0]      cnt_q;    // remaining execute cycles after the current one
  logic [2:0]      op_q;     // op captured at accept; later req_op changes are ignored
  logic [IW-1:0]   gnt_q;    // requester owning the datapath
  logic [IW-1:0]   ptr_q;    // round-robin start point for the next search
  logic            op_en_q;
  logic            busy_q;
  logic [NREQ-1:0] done_q;

  // Picker results
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  // Next-state helpers
  logic [2:0]      op_sel_d;
  logic [2:0]      cnt_d;
  logic [IW-1:0]   ptr_d;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Op of the requester the picker selected.
  always_comb begin
    op_sel_d = OP_A;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        op_sel_d = req_op[3*i +: 3];
      end
    end
  end

  // Counter preload: the accept edge already starts the first execute cycle,
  // so the count is one less than the latency.
  assign cnt_d = op_lat(op_sel_d, ARITH_LAT, OTHER_LAT) - 3'd1;

  // A locked owner keeps priority; otherwise priority moves to the next index.
  always_comb begin
    if (req_lock[gnt_q]) begin
      ptr_d = gnt_q;
    end else if (gnt_q == IW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_q + 1'b1;
    end
  end

  // Accept is combinational in IDLE; suppressed during reset because the
  // op would be discarded by the reset edge.
  assign req_ready = (state_q == ST_IDLE && !rst) ? pick_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_A;
      gnt_q   <= '0;
      ptr_q   <= '0;
      op_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            op_q    <= op_sel_d;
            gnt_q   <= pick_idx;
            cnt_q   <= cnt_d;
            op_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 3'd0) begin
            op_en_q <= 1'b0;
            done_q  <= NREQ'(1) << gnt_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // op_out is forced to 000 outside EXEC so an idle decoder input is stable.
  assign op_out = op_en_q ? op_q : OP_A;
  assign op_en  = op_en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
module tb_alu_op_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [3*N-1:0] req_op    = '0;
  logic [N-1:0]   req_lock  = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   done;
  logic [2:0]     op_out;
  logic           op_en;
  logic           busy;

  alu_op_arbiter #(
    .NREQ      (N),
    .ARITH_CYC (2),
    .OTHER_CYC (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .done      (done),
    .op_out    (op_out),
    .op_en     (op_en),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Latency rule: add/sub take 2 cycles, everything else 1.
  function automatic int m_lat(input logic [2:0] op);
    return (op == 3'd4 || op == 3'd5) ? 2 : 1;
  endfunction

  // Lowest-distance valid requester from p, wrapping modulo N; -1 if none.
  function automatic int m_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    int         g;
    logic [2:0] op;
    int         lat;
    int         t;
  } txn_t;

  txn_t sbq[$];       // accepted ops awaiting completion
  int   glog[$];      // grant indices observed, for directed checks
  int   cyc       = 0;
  int   m_ptr     = 0;
  int   m_free_at = 0;
  bit   started   = 1'b0;

  logic [N-1:0] e_ready, e_done, act_ready_q;
  logic         e_en, e_busy;
  logic [2:0]   e_op;
  int           e_g;
  txn_t         h, nt;

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    e_ready = '0;
    e_done  = '0;
    e_en    = 1'b0;
    e_busy  = 1'b0;
    e_op    = 3'b000;
    if (started) begin
      if (sbq.size() > 0) begin
        h = sbq[0];
        if (cyc >= h.t + 1 && cyc <= h.t + h.lat) begin
          e_en = 1'b1;
          e_op = h.op;
        end
        if (cyc >= h.t + 1 && cyc <= h.t + h.lat + 1) e_busy = 1'b1;
        if (cyc == h.t + h.lat + 1) e_done[h.g] = 1'b1;
      end
      if (!rst && cyc >= m_free_at) begin
        e_g = m_pick(req_valid, m_ptr);
        if (e_g >= 0) e_ready[e_g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("op_en",     32'(op_en),     32'(e_en));
      chk("op_out",    32'(op_out),    32'(e_op));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("done",      32'(done),      32'(e_done));
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      if (e_ready != '0) begin
        nt.g   = e_g;
        nt.op  = req_op[3*e_g +: 3];
        nt.lat = m_lat(nt.op);
        nt.t   = cyc;
        sbq.push_back(nt);
        m_free_at = cyc + nt.lat + 2;
      end
      if (done != '0 || e_done != '0) begin
        if (e_done != '0) begin
          h = sbq.pop_front();
          m_ptr = req_lock[h.g] ? h.g : (h.g + 1) % N;
        end
      end
      if (rst) begin
        sbq.delete();
        m_ptr     = 0;
        m_free_at = cyc + 1;
      end
    end else if (rst) begin
      started   = 1'b1;
      m_ptr     = 0;
      m_free_at = cyc + 1;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  function automatic logic [11:0] ops4(input logic [2:0] o3, input logic [2:0] o2,
                                       input logic [2:0] o1, input logic [2:0] o0);
    return {o3, o2, o1, o0};
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lk, input logic [11:0] ops);
    @(posedge clk);
    #1;
    req_valid = v;
    req_lock  = lk;
    req_op    = ops;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, req_op);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_log(input string name, input int n,
                           input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_grant_count"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++) begin
      chk($sformatf("%s_grant%0d", name, i), 32'(glog[i]), 32'(e[i]));
    end
    glog.delete();
  endtask

  logic [N-1:0]   rv, acc;
  logic [3*N-1:0] rops;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    glog.delete();

    // T1: single add from requester 0.
    step(4'b0001, 4'b0000, ops4(OP_A, OP_A, OP_A, OP_ADD));
    idle(5);
    check_log("t1", 1, 0, 0, 0, 0);

    // T2: two requesters always valid, no lock -> strict alternation.
    for (int i = 0; i < 12; i++) step(4'b0011, 4'b0000, ops4(OP_A, OP_A, OP_AWE, OP_B));
    idle(3);
    check_log("t2", 4, 1, 0, 1, 0);

    // T3: requester 0 locked -> three grants in a row, then unlock hands over to 1.
    do_reset();
    for (int i = 0; i < 11; i++) step(4'b0011, 4'b0001, ops4(OP_A, OP_A, OP_AWE, OP_SUB));
    step(4'b0011, 4'b0000, ops4(OP_A, OP_A, OP_AWE, OP_SUB));
    step(4'b0011, 4'b0000, ops4(OP_A, OP_A, OP_AWE, OP_SUB));
    idle(4);
    check_log("t3", 4, 0, 0, 0, 1);

    // T4: reset in the 2nd execute cycle of an add aborts it without done.
    step(4'b0001, 4'b0000, ops4(OP_A, OP_A, OP_D, OP_ADD));
    step(4'b0000, 4'b0000, ops4(OP_A, OP_A, OP_D, OP_ADD));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    step(4'b0010, 4'b0000, ops4(OP_A, OP_A, OP_D, OP_ADD));
    idle(4);
    check_log("t4", 2, 0, 1, 0, 0);

    // T5: move ptr to 3, then confirm wrap search.
    step(4'b0100, 4'b0000, ops4(OP_A, OP_C, OP_A, OP_A));
    idle(2);
    step(4'b1010, 4'b1000, ops4(OP_F, OP_A, OP_AWE, OP_A));
    step(4'b0010, 4'b1000, ops4(OP_F, OP_A, OP_AWE, OP_A));
    step(4'b0010, 4'b1000, ops4(OP_F, OP_A, OP_AWE, OP_A));
    step(4'b0010, 4'b0000, ops4(OP_F, OP_A, OP_AWE, OP_A));
    idle(4);
    check_log("t5", 3, 2, 3, 1, 0);

    // T6: long idle with garbage ops on the bus and random locks.
    for (int i = 0; i < 20; i++) step('0, 4'($urandom_range(0, 15)), 12'($urandom));
    check_log("t6", 0, 0, 0, 0, 0);

    // Random phase: protocol-respecting requesters, occasional reset.
    rv   = '0;
    rops = req_op;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !rv[i]) begin
          rv[i]          = ($urandom_range(0, 3) != 0);
          rops[3*i +: 3] = 3'($urandom_range(0, 7));
        end
      end
      req_valid = rv;
      req_op    = rops;
      req_lock  = 4'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
